// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration-frame transmitter.
package cfg_frame_pkg;

    localparam int FRAME_BYTES = 10;

    // Frame position of each field; 16-bit fields occupy idx (MSB) and idx+1 (LSB).
    localparam int IDX_TELE = 0;
    localparam int IDX_REP  = 1;
    localparam int IDX_HIGH = 2;
    localparam int IDX_LOW  = 4;
    localparam int IDX_IMP  = 6;
    localparam int IDX_STOP = 8;

    typedef enum logic [2:0] {
        TOP_IDLE,
        TOP_LOAD,
        TOP_SEND,
        TOP_GAP,
        TOP_FIN
    } top_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    // Element [i] is the byte sent in position i of the frame.
    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    function automatic frame_t pack_frame(
        input logic [7:0]  tele,
        input logic [7:0]  rep_no,
        input logic [15:0] high_on,
        input logic [15:0] low_on,
        input logic [15:0] imp_on,
        input logic [15:0] stop_on
    );
        frame_t f;
        f = '0;
        f[IDX_TELE]   = tele;
        f[IDX_REP]    = rep_no;
        f[IDX_HIGH]   = high_on[15:8];
        f[IDX_HIGH+1] = high_on[7:0];
        f[IDX_LOW]    = low_on[15:8];
        f[IDX_LOW+1]  = low_on[7:0];
        f[IDX_IMP]    = imp_on[15:8];
        f[IDX_IMP+1]  = imp_on[7:0];
        f[IDX_STOP]   = stop_on[15:8];
        f[IDX_STOP+1] = stop_on[7:0];
        return f;
    endfunction

endpackage

// File: rtl/cfg_byte_tx.sv
// 8N1 UART byte serializer, LSB first, CLKS_PER_BIT clocks per bit.
//
// state     | meaning
// ----------+------------------------------------------------
// SER_IDLE  | line high, waiting for load
// SER_START | start bit (low)
// SER_DATA  | eight data bits, LSB first
// SER_STOP  | stop bit (high); byte_done on its last cycle
module cfg_byte_tx
    import cfg_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;

    // State and line register; reset releases the line high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d carries the level of the next cycle so tx stays registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        byte_done = 1'b0;
        case (state_q)
            SER_IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d = SER_START;
                    cnt_d   = BIT_LAST;
                    sh_d    = data;
                    tx_d    = 1'b0;
                end
            end
            SER_START: begin
                if (cnt_q == '0) begin
                    state_d = SER_DATA;
                    cnt_d   = BIT_LAST;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SER_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_LAST;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        sh_d = {1'b0, sh_q[7:1]};
                        tx_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SER_STOP: begin
                if (cnt_q == '0) begin
                    byte_done = 1'b1;
                    state_d   = SER_IDLE;
                    tx_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = SER_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/cfg_frame_tx.sv
// Sends the 10-byte configuration frame as UART 8N1 bytes with optional idle gaps.
//
// state    | meaning
// ---------+--------------------------------------------------------
// TOP_IDLE | line idle; start captures the fields into the shadow
// TOP_LOAD | hand shadow byte[byte_idx] to the serializer
// TOP_SEND | serializer busy; wait for byte_done
// TOP_GAP  | hold the line high for GAP_BITS bit-times
// TOP_FIN  | one-cycle done pulse, busy already low
module cfg_frame_tx
    import cfg_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  tele,
    input  logic [7:0]  rep_no,
    input  logic [15:0] high_on,
    input  logic [15:0] low_on,
    input  logic [15:0] imp_on,
    input  logic [15:0] stop_on,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [3:0]  byte_idx
);

    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
    localparam logic [3:0]    IDX_LAST = 4'(FRAME_BYTES - 1);

    top_state_e    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    frame_t        shadow_q, shadow_d;
    logic          ser_load;
    logic          ser_done;

    // Frame sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= TOP_IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
        end
    end

    // Sequencer next-state logic; start only matters in IDLE, so it is never queued.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        ser_load = 1'b0;
        case (state_q)
            TOP_IDLE: begin
                if (start) begin
                    state_d  = TOP_LOAD;
                    idx_d    = '0;
                    shadow_d = pack_frame(tele, rep_no, high_on, low_on, imp_on, stop_on);
                end
            end
            TOP_LOAD: begin
                ser_load = 1'b1;
                state_d  = TOP_SEND;
            end
            TOP_SEND: begin
                if (ser_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = TOP_FIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (GAP_BITS > 0) begin
                            state_d = TOP_GAP;
                            gap_d   = GAP_LAST;
                        end else begin
                            state_d = TOP_LOAD;
                        end
                    end
                end
            end
            TOP_GAP: begin
                if (gap_q == '0) begin
                    state_d = TOP_LOAD;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            TOP_FIN: begin
                state_d = TOP_IDLE;
            end
            default: begin
                state_d = TOP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    cfg_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .data     (shadow_q[idx_q]),
        .tx       (tx),
        .byte_done(ser_done)
    );

    assign busy     = (state_q == TOP_LOAD) || (state_q == TOP_SEND) || (state_q == TOP_GAP);
    assign done     = (state_q == TOP_FIN);
    assign byte_idx = idx_q;

endmodule

// File: tb/tb_cfg_frame_tx.sv
// Bench for cfg_frame_tx: three instances (GAP_BITS 1, 0, 3) watched by a UART receiver model.
module tb_cfg_frame_tx;

    localparam int CPB = 4;
    localparam int NV  = 7;

    typedef struct packed {
        logic [7:0]       tele;
        logic [7:0]       rep;
        logic [15:0]      hi;
        logic [15:0]      lo;
        logic [15:0]      imp;
        logic [15:0]      stp;
        logic [9:0][7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [7:0]  tele, rep_no;
    logic [15:0] high_on, low_on, imp_on, stop_on;
    logic [2:0]  tx_v, busy_v, done_v;
    logic [3:0]  idx_v [3];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cfg_frame_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut_g1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .tele(tele), .rep_no(rep_no),
        .high_on(high_on), .low_on(low_on), .imp_on(imp_on), .stop_on(stop_on),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .byte_idx(idx_v[0]));

    cfg_frame_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_g0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .tele(tele), .rep_no(rep_no),
        .high_on(high_on), .low_on(low_on), .imp_on(imp_on), .stop_on(stop_on),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .byte_idx(idx_v[1]));

    cfg_frame_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(3)) dut_g3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .tele(tele), .rep_no(rep_no),
        .high_on(high_on), .low_on(low_on), .imp_on(imp_on), .stop_on(stop_on),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .byte_idx(idx_v[2]));

    function automatic int gap_of(input int g);
        case (g)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    // Idle gap between stop bit end and next start bit, and tx-fall-to-done length.
    function automatic int idle_of(input int g);
        return gap_of(g) * CPB + 1;
    endfunction

    function automatic int frame_len(input int g);
        return 100 * CPB + 9 * idle_of(g);
    endfunction

    // Expected byte stream: 8-bit fields as-is, 16-bit fields MSB byte first.
    function automatic logic [9:0][7:0] model_bytes(input vec_t v);
        logic [7:0]      q[$];
        logic [15:0]     w[4];
        logic [9:0][7:0] r;
        q.push_back(v.tele);
        q.push_back(v.rep);
        w[0] = v.hi; w[1] = v.lo; w[2] = v.imp; w[3] = v.stp;
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'(w[i] >> 8));
            q.push_back(8'(w[i] & 16'h00FF));
        end
        for (int i = 0; i < 10; i++) r[i] = q[i];
        return r;
    endfunction

    // UART receiver model state, one lane per instance; only this block writes it.
    int         rx_cnt   [3] = '{0, 0, 0};
    logic [7:0] rx_sh    [3];
    int         fall_cur [3];
    logic [7:0] rx_byte  [3][256];
    int         rx_fall  [3][256];
    logic [3:0] rx_idx   [3][256];
    int         rx_n     [3] = '{0, 0, 0};
    int         done_t   [3][64];
    logic [3:0] done_idx [3][64];
    int         done_n   [3] = '{0, 0, 0};
    int         busy_err [3] = '{0, 0, 0};
    int         frame_err[3] = '{0, 0, 0};
    int         done_busy[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst) begin
                rx_cnt[g] <= 0;
            end else if (rx_cnt[g] == 0) begin
                if (tx_v[g] == 1'b0) begin
                    fall_cur[g] <= cyc;
                    rx_cnt[g]   <= 1;
                end
            end else begin
                rx_cnt[g] <= rx_cnt[g] + 1;
                if (busy_v[g] == 1'b0) busy_err[g] <= busy_err[g] + 1;
                if (rx_cnt[g] >= CPB && rx_cnt[g] < 9 * CPB && (rx_cnt[g] % CPB) == CPB / 2)
                    rx_sh[g] <= {tx_v[g], rx_sh[g][7:1]};
                if (rx_cnt[g] == 9 * CPB + CPB / 2) begin
                    if (tx_v[g] != 1'b1) frame_err[g] <= frame_err[g] + 1;
                    rx_byte[g][rx_n[g][7:0]] <= rx_sh[g];
                    rx_fall[g][rx_n[g][7:0]] <= fall_cur[g];
                    rx_idx[g][rx_n[g][7:0]]  <= idx_v[g];
                    rx_n[g]   <= rx_n[g] + 1;
                    rx_cnt[g] <= 0;
                end
            end
            if (done_v[g]) begin
                done_t[g][done_n[g][5:0]]   <= cyc;
                done_idx[g][done_n[g][5:0]] <= idx_v[g];
                done_n[g] <= done_n[g] + 1;
                if (busy_v[g]) done_busy[g] <= done_busy[g] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_fields(input vec_t v);
        tele = v.tele; rep_no = v.rep; high_on = v.hi;
        low_on = v.lo; imp_on = v.imp; stop_on = v.stp;
    endtask

    // One frame on lane g; optional start poke while busy at byte poke_idx, or in the FIN cycle.
    task automatic run_frame(input int g, input vec_t v, input int poke_idx, input bit fin_start);
        int  r0, d0, b0, f0, db0, t0;
        bit  poked, got;
        string tag;
        r0 = rx_n[g]; d0 = done_n[g]; b0 = busy_err[g]; f0 = frame_err[g]; db0 = done_busy[g];
        poked = 0; got = 0;
        tag = $sformatf("lane%0d", g);
        step();
        drive_fields(v);
        start_v[g] = 1'b1;
        t0 = cyc;
        step();
        start_v[g] = 1'b0;
        for (int b = 0; b < 3000 && !got; b++) begin
            step();
            if (poke_idx >= 0 && !poked && idx_v[g] == 4'(poke_idx)) begin
                tele = 8'hFF; rep_no = 8'hFF; high_on = 16'hFFFF;
                low_on = 16'hFFFF; imp_on = 16'hFFFF; stop_on = 16'hFFFF;
                start_v[g] = 1'b1;
                poked = 1;
            end else begin
                start_v[g] = 1'b0;
            end
            if (done_n[g] != d0) begin
                got = 1;
                if (fin_start) start_v[g] = 1'b1;
            end
        end
        chk({tag, " done_timeout"}, 64'(got), 64'd1);
        step();
        start_v[g] = 1'b0;
        repeat (200) step();
        chk({tag, " byte_count"}, 64'(rx_n[g] - r0), 64'd10);
        chk({tag, " done_count"}, 64'(done_n[g] - d0), 64'd1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s byte%0d", tag, k), 64'(rx_byte[g][8'(r0 + k)]), 64'(v.exp[k]));
            chk($sformatf("%s idx%0d", tag, k), 64'(rx_idx[g][8'(r0 + k)]), 64'(k));
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s idle%0d", tag, k),
                64'(rx_fall[g][8'(r0 + k + 1)] - rx_fall[g][8'(r0 + k)] - 10 * CPB), 64'(idle_of(g)));
        chk({tag, " latency"}, 64'(rx_fall[g][8'(r0)] - t0), 64'd2);
        chk({tag, " frame_len"}, 64'(done_t[g][6'(d0)] - rx_fall[g][8'(r0)]), 64'(frame_len(g)));
        chk({tag, " fin_idx"}, 64'(done_idx[g][6'(d0)]), 64'd0);
        chk({tag, " busy_drop"}, 64'(busy_err[g] - b0), 64'd0);
        chk({tag, " framing"}, 64'(frame_err[g] - f0), 64'd0);
        chk({tag, " busy_in_fin"}, 64'(done_busy[g] - db0), 64'd0);
        if (poke_idx >= 0) chk({tag, " poke_done"}, 64'(poked), 64'd1);
    endtask

    vec_t       vecs [NV];
    logic [7:0] spec_exp [10];

    initial begin
        int r0, d0, lows, t_idx;
        bit hit;

        spec_exp = '{8'h64, 8'h32, 8'h34, 8'h08, 8'h84, 8'h03, 8'h98, 8'h3A, 8'h50, 8'hC3};
        vecs[0].tele = 8'h64; vecs[0].rep = 8'h32; vecs[0].hi = 16'h3408;
        vecs[0].lo = 16'h8403; vecs[0].imp = 16'h983A; vecs[0].stp = 16'h50C3;
        for (int k = 0; k < 10; k++) vecs[0].exp[k] = spec_exp[k];
        vecs[1] = '1;
        for (int k = 0; k < 10; k++) vecs[1].exp[k] = 8'hFF;
        for (int i = 2; i < NV; i++) begin
            vecs[i].tele = 8'($urandom);  vecs[i].rep = 8'($urandom);
            vecs[i].hi   = 16'($urandom); vecs[i].lo  = 16'($urandom);
            vecs[i].imp  = 16'($urandom); vecs[i].stp = 16'($urandom);
            vecs[i].exp  = model_bytes(vecs[i]);
        end

        rst = 1'b0;
        start_v = '0;
        drive_fields('0);
        repeat (3) step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset tx%0d", g), 64'(tx_v[g]), 64'd1);
            chk($sformatf("reset busy%0d", g), 64'(busy_v[g]), 64'd0);
            chk($sformatf("reset done%0d", g), 64'(done_v[g]), 64'd0);
            chk($sformatf("reset idx%0d", g), 64'(idx_v[g]), 64'd0);
        end
        rst = 1'b1;
        repeat (3) step();

        for (int i = 0; i < NV; i++) run_frame(i % 3, vecs[i], -1, 1'b0);

        // Start while busy with all-FF fields: ignored, frame in flight unchanged.
        run_frame(0, vecs[0], 3, 1'b0);
        // Start only during the FIN cycle: ignored, no follow-up frame.
        run_frame(1, vecs[2], -1, 1'b1);
        run_frame(2, vecs[3], -1, 1'b1);

        // Start held high across three frames.
        r0 = rx_n[0]; d0 = done_n[0];
        step();
        drive_fields(vecs[4]);
        start_v[0] = 1'b1;
        hit = 0;
        for (int b = 0; b < 5000 && !hit; b++) begin
            step();
            if (done_n[0] - d0 >= 3) hit = 1;
        end
        start_v[0] = 1'b0;
        chk("held done_timeout", 64'(hit), 64'd1);
        repeat (300) step();
        chk("held done_count", 64'(done_n[0] - d0), 64'd3);
        chk("held byte_count", 64'(rx_n[0] - r0), 64'd30);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 10; k++)
                chk($sformatf("held f%0d byte%0d", f, k),
                    64'(rx_byte[0][8'(r0 + 10 * f + k)]), 64'(vecs[4].exp[k]));
        for (int f = 1; f < 3; f++)
            chk($sformatf("held restart%0d", f),
                64'(rx_fall[0][8'(r0 + 10 * f)] - done_t[0][6'(d0 + f - 1)]), 64'd3);

        // Reset during the start bit of byte 5.
        step();
        drive_fields(vecs[5]);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        hit = 0;
        for (int b = 0; b < 3000 && !hit; b++) begin
            step();
            if (idx_v[0] == 4'd5 && tx_v[0] == 1'b0) hit = 1;
        end
        chk("rst reach_byte5", 64'(hit), 64'd1);
        t_idx = 32'(idx_v[0]);
        rst = 1'b0;
        #1;
        chk("rst tx_async", 64'(tx_v[0]), 64'd1);
        chk("rst busy_async", 64'(busy_v[0]), 64'd0);
        chk("rst idx_async", 64'(idx_v[0]), 64'd0);
        chk("rst done_async", 64'(done_v[0]), 64'd0);
        step();
        rst = 1'b1;
        r0 = rx_n[0]; d0 = done_n[0]; lows = 0;
        for (int b = 0; b < 2000; b++) begin
            step();
            if (tx_v[0] == 1'b0 || busy_v[0] == 1'b1) lows++;
        end
        chk("rst quiet_line", 64'(lows), 64'd0);
        chk("rst no_bytes", 64'(rx_n[0] - r0), 64'd0);
        chk("rst no_done", 64'(done_n[0] - d0), 64'd0);
        if (t_idx != 5) chk("rst idx_before", 64'(t_idx), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
